mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
Parametrised writeback-stage pipeline register that replaces a fixed-width, freeze-only MEM/WB latch. It adds a valid/ready handshake and an optional skid entry, so back-pressure from the register file or special-register port never creates a combinational ready path. It also provides a synchronous flush, bubble gating of write enables, a resolved writeback value, and a saturating stall counter. It sits between the memory-access stage and the register-file write port.

Parameters:
DATA_W, 16, width of the memory read data, ALU result and writeback value.
REG_ID_W, 3, width of the destination register index.
SPEC_W, 2, width of the special-register write select.
SKID, 1, 1 = two-entry elastic stage (main plus skid); 0 = single entry with combinational in_ready.
CNT_W, 8, width of the stall counter.

Ports:
CLK  in  1  clock; all state changes on the rising edge
RST  in  1  reset; synchronous, active-low
flush  in  1  discard all held entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry this cycle
writeSpecRegIn  in  SPEC_W  special-register write select
memtoRegIn  in  1  1 = write back memory data, 0 = write back ALU result
regWriteIn  in  1  general-register write enable
dataIn  in  DATA_W  memory read data
ALUResultIn  in  DATA_W  ALU result
registerToWriteIdIn  in  REG_ID_W  destination register
out_valid  out  1  head entry valid
out_ready  in  1  writeback consumes the head entry
writeSpecRegOut  out  SPEC_W  gated special-register write select
memtoRegOut  out  1  head memtoReg
regWriteOut  out  1  gated general-register write enable
wbDataOut  out  DATA_W  resolved writeback value
outRegisterToWriteId  out  REG_ID_W  head destination register
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (RST=0 at a rising edge):
  - Both entries are cleared and the stage goes to EMPTY.
  - All outputs read 0 except in_ready. In SKID=1, in_ready reads 1 the cycle after reset. In SKID=0, in_ready follows its combinational equation: 1 while RST=0 and 1 once the stage is EMPTY.
  - No capture happens during reset, whatever in_valid is.
  - Reset in the middle of traffic discards everything held.
- Transfer rules:
  - Accept when in_valid && in_ready.
  - Retire when out_valid && out_ready.
  - Entry order is preserved strictly; no entry is ever duplicated or dropped except by flush or reset.
- SKID=1 state machine (EMPTY, ONE, TWO):
  - in_ready is registered; it is 1 in EMPTY and ONE, and 0 in TWO.
  - EMPTY: accept goes to ONE, with the entry in main.
  - ONE:
    - Accept without retire goes to TWO, with the new entry in skid.
    - Retire without accept goes to EMPTY.
    - Accept and retire together stays in ONE, and the new entry loads main.
  - TWO:
    - Retire goes to ONE, and skid moves to main the same edge.
    - No accept is possible in TWO.
- SKID=0 (single entry, states EMPTY and ONE):
  - in_ready = !out_valid || out_ready, computed combinationally.
  - Accept loads main; simultaneous accept and retire replaces main.
- Latency: out_valid rises on the first edge after an accept into EMPTY, i.e. 1 cycle. There is no combinational path from in_* to out_*.
- Outputs are driven from main:
  - wbDataOut = memtoRegOut ? stored dataIn : stored ALUResultIn, selected combinationally.
  - regWriteOut = out_valid && stored regWrite.
  - writeSpecRegOut = out_valid ? stored select : 0.
  - A bubble therefore can never write.
  - When out_valid=0, wbDataOut, memtoRegOut and outRegisterToWriteId read 0.
- Flush:
  - Synchronous. It clears both entries and moves to EMPTY, so out_valid=0 the next cycle.
  - Flush takes priority over a simultaneous accept (the input is dropped) and over a simultaneous retire (the retire still counts as consumed for that cycle).
  - Reset takes priority over flush.
- stall_cnt:
  - Increments on every cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset; flush does not clear it.
- Widths: all payload fields are stored at their exact widths; no arithmetic other than the counter.

Test Plan:
- Reset and pass-through, SKID=1: hold RST=0 for 2 cycles -> out_valid=0, regWriteOut=0, in_ready=1. Release; send one entry with ALUResultIn=16'h1234, memtoRegIn=0, regWriteIn=1, id=3, out_ready=1 -> next cycle out_valid=1, wbDataOut=16'h1234, outRegisterToWriteId=3, regWriteOut=1.
- Memory select: dataIn=16'hBEEF, ALUResultIn=16'h0001, memtoRegIn=1 -> wbDataOut=16'hBEEF.
- Back-pressure, SKID=1: out_ready=0 while sending entries A=1, B=2, C=3 on consecutive cycles.
  - Required: A is in main, B is in skid, and in_ready=0 from the cycle after B is accepted, so C is held upstream.
  - Then raise out_ready: outputs read 1, 2, 3 in order with no loss.
  - stall_cnt equals the number of stalled cycles.
- Flush while full: in state TWO assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, regWriteOut=0, and the flushed input never appears.
- Bubble gating: send an entry with regWriteIn=1 and writeSpecRegIn=2'b10, then idle -> after it retires, regWriteOut=0 and writeSpecRegOut=0.
- stall_cnt saturation: CNT_W=4, hold out_ready=0 for 20 cycles with a valid entry -> stall_cnt stops at 15 and does not wrap. SKID=0 regression: the same ordering test gives in_ready = !out_valid || out_ready each cycle.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bundle: upstream handshake and payload, writeback outputs,
// flush and stall counter.
interface mem_wb_stage_if #(
    parameter int DATA_W   = 16,
    parameter int REG_ID_W = 3,
    parameter int SPEC_W   = 2,
    parameter int CNT_W    = 8
);
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [SPEC_W-1:0]   writeSpecRegIn;
    logic                memtoRegIn;
    logic                regWriteIn;
    logic [DATA_W-1:0]   dataIn;
    logic [DATA_W-1:0]   ALUResultIn;
    logic [REG_ID_W-1:0] registerToWriteIdIn;
    logic                out_valid;
    logic                out_ready;
    logic [SPEC_W-1:0]   writeSpecRegOut;
    logic                memtoRegOut;
    logic                regWriteOut;
    logic [DATA_W-1:0]   wbDataOut;
    logic [REG_ID_W-1:0] outRegisterToWriteId;
    logic [CNT_W-1:0]    stall_cnt;

    modport master (
        output flush, in_valid, writeSpecRegIn, memtoRegIn, regWriteIn,
        output dataIn, ALUResultIn, registerToWriteIdIn, out_ready,
        input  in_ready, out_valid, writeSpecRegOut, memtoRegOut,
        input  regWriteOut, wbDataOut, outRegisterToWriteId, stall_cnt
    );

    modport slave (
        input  flush, in_valid, writeSpecRegIn, memtoRegIn, regWriteIn,
        input  dataIn, ALUResultIn, registerToWriteIdIn, out_ready,
        output in_ready, out_valid, writeSpecRegOut, memtoRegOut,
        output regWriteOut, wbDataOut, outRegisterToWriteId, stall_cnt
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with valid/ready handshake, optional skid entry,
// flush, bubble-gated write enables and a saturating stall counter.
module mem_wb_stage #(
    parameter int DATA_W   = 16,
    parameter int REG_ID_W = 3,
    parameter int SPEC_W   = 2,
    parameter int SKID     = 1,
    parameter int CNT_W    = 8
) (
    input logic          CLK,
    input logic          RST,
    mem_wb_stage_if.slave bus
);
    typedef struct packed {
        logic [SPEC_W-1:0]   spec;
        logic                m2r;
        logic                rw;
        logic [DATA_W-1:0]   data;
        logic [DATA_W-1:0]   alu;
        logic [REG_ID_W-1:0] rd;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    entry_t           main_e;
    entry_t           skid_e;
    entry_t           in_e;
    logic             rdy_q;
    logic             valid;
    logic             acc;
    logic             ret;
    logic [CNT_W-1:0] cnt;

    assign in_e = '{
        spec: bus.writeSpecRegIn,
        m2r:  bus.memtoRegIn,
        rw:   bus.regWriteIn,
        data: bus.dataIn,
        alu:  bus.ALUResultIn,
        rd:   bus.registerToWriteIdIn
    };

    assign valid = (state != EMPTY);

    // Skid mode breaks the ready path with a register; single-entry
    // mode lets a retiring head make room in the same cycle.
    assign bus.in_ready = (SKID != 0) ? rdy_q
                        : (!RST || !valid || bus.out_ready);

    assign acc = bus.in_valid && bus.in_ready;
    assign ret = valid && bus.out_ready;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state  <= EMPTY;
            main_e <= '0;
            skid_e <= '0;
            rdy_q  <= 1'b1;
        end else if (bus.flush) begin
            state  <= EMPTY;
            main_e <= '0;
            skid_e <= '0;
            rdy_q  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        main_e <= in_e;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (acc && ret) begin
                        main_e <= in_e;
                    end else if (acc) begin
                        skid_e <= in_e;
                        state  <= TWO;
                        rdy_q  <= 1'b0;
                    end else if (ret) begin
                        main_e <= '0;
                        state  <= EMPTY;
                    end
                end
                TWO: begin
                    if (ret) begin
                        main_e <= skid_e;
                        skid_e <= '0;
                        state  <= ONE;
                        rdy_q  <= 1'b1;
                    end
                end
                default: begin
                    state <= EMPTY;
                    rdy_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt <= '0;
        end else if (valid && !bus.out_ready && cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bus.out_valid            = valid;
    assign bus.memtoRegOut          = valid && main_e.m2r;
    assign bus.regWriteOut          = valid && main_e.rw;
    assign bus.writeSpecRegOut      = valid ? main_e.spec : '0;
    assign bus.outRegisterToWriteId = valid ? main_e.rd : '0;
    assign bus.wbDataOut            = !valid     ? '0
                                    : main_e.m2r ? main_e.data
                                    :              main_e.alu;
    assign bus.stall_cnt            = cnt;
endmodule
